vga_sync_decoder: RTL

- Receive-side counterpart of the 640x480@60 VGA timing generator: consumes active-low vga_hs/vga_vs plus 4:4:4 RGB and recovers pixel coordinates, per-pixel valid strobes and frame/line markers.
- Checks line and frame periods, locks after one clean frame, flags timing errors.
- Used as loopback checker for the generator and as front end of a frame-capture path.

---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/vga_sync_decoder_if.sv | 41 ++++
 rtl/vga_edge_det.sv | 26 ++
 rtl/vga_sync_decoder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA timing constants, FSM encoding and small counter helpers shared by the sync decoder.
package vga_timing_pkg;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
    localparam int VGA_HA0     = VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_VA0     = VGA_V_SYNC + VGA_V_BACK;

    localparam int RGB_W = 12;
    localparam int CNT_W = 10;
    localparam int ERR_W = 8;

    typedef logic [1:0] fsm_state_t;

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_CHECK    = 2'd1;
    localparam logic [1:0] ST_LOCKED   = 2'd2;

    // Counters stick at all-ones so a lost sync can never wrap back into a plausible period.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/vga_sync_decoder_if.sv
// Bundle between a VGA source (master) and the sync decoder (slave).
// Optional VGA_SYNC_DECODER_STATS_EN adds the measured period signals.
interface vga_sync_decoder_if;
    import vga_timing_pkg::*;

    logic             pix_ce;
    logic             vga_hs;
    logic             vga_vs;
    logic [3:0]       vga_r;
    logic [3:0]       vga_g;
    logic [3:0]       vga_b;
    logic [CNT_W-1:0] pix_x;
    logic [CNT_W-1:0] pix_y;
    logic [RGB_W-1:0] pix_rgb;
    logic             pix_valid;
    logic             line_start;
    logic             frame_start;
    logic             locked;
    logic [ERR_W-1:0] err_cnt;
`ifdef VGA_SYNC_DECODER_STATS_EN
    logic [CNT_W-1:0] meas_h_total;
    logic [CNT_W-1:0] meas_v_total;
`endif

    modport master (
        output pix_ce, vga_hs, vga_vs, vga_r, vga_g, vga_b,
`ifdef VGA_SYNC_DECODER_STATS_EN
        input  meas_h_total, meas_v_total,
`endif
        input  pix_x, pix_y, pix_rgb, pix_valid, line_start, frame_start, locked, err_cnt
    );

    modport slave (
        input  pix_ce, vga_hs, vga_vs, vga_r, vga_g, vga_b,
`ifdef VGA_SYNC_DECODER_STATS_EN
        output meas_h_total, meas_v_total,
`endif
        output pix_x, pix_y, pix_rgb, pix_valid, line_start, frame_start, locked, err_cnt
    );

endinterface

// File: rtl/vga_edge_det.sv
// Pixel-enable qualified two-stage sampler for an active-low sync; fall flags the 1->0 transition.
module vga_edge_det (
    input  logic clk_50,
    input  logic rst,
    input  logic ce,
    input  logic d,
    output logic fall
);

    logic s1;
    logic s2;

    // Idle-high reset so a sync already low after reset still produces an edge.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else if (ce) begin
            s1 <= d;
            s2 <= s1;
        end
    end

    assign fall = s2 & ~s1;

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: recovers pixel coordinates/strobes, checks line and frame periods, locks.
// Optional VGA_SYNC_DECODER_STATS_EN adds meas_h_total/meas_v_total outputs.
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK
) (
    input  logic              clk_50,
    input  logic              rst,
    vga_sync_decoder_if.slave bus
);

    // state       | meaning
    // ST_UNLOCKED | no trusted timing; waiting for a vs edge to open a check window
    // ST_CHECK    | timing one full frame; any error restarts the window at the next vs edge
    // ST_LOCKED   | timing trusted, pixels emitted; any error drops lock and counts

    localparam int H_TOTAL_I = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL_I = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HA0_I     = H_SYNC + H_BACK;
    localparam int VA0_I     = V_SYNC + V_BACK;
    localparam int HA1_I     = HA0_I + H_VISIBLE;
    localparam int VA1_I     = VA0_I + V_VISIBLE;

    localparam logic [CNT_W:0]   H_TOTAL = H_TOTAL_I[CNT_W:0];
    localparam logic [CNT_W:0]   V_TOTAL = V_TOTAL_I[CNT_W:0];
    localparam logic [CNT_W-1:0] HA0     = HA0_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] VA0     = VA0_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] HA1     = HA1_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] VA1     = VA1_I[CNT_W-1:0];

    logic             hs_fall;
    logic             vs_fall;
    logic             hs_edge;
    logic             vs_edge;
    logic [RGB_W-1:0] rgb_s1;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;
    logic [CNT_W:0]   h_len;
    logic [CNT_W:0]   v_len;
    fsm_state_t       state;
    fsm_state_t       state_next;
    logic             win_err;
    logic             win_err_next;
    logic             line_err;
    logic             frame_err;
    logic             err_inc;
    logic             active;

    vga_edge_det u_hs_det (
        .clk_50 (clk_50),
        .rst    (rst),
        .ce     (bus.pix_ce),
        .d      (bus.vga_hs),
        .fall   (hs_fall)
    );

    vga_edge_det u_vs_det (
        .clk_50 (clk_50),
        .rst    (rst),
        .ce     (bus.pix_ce),
        .d      (bus.vga_vs),
        .fall   (vs_fall)
    );

    always_ff @(posedge clk_50) begin
        if (rst) begin
            rgb_s1 <= '1;
        end else if (bus.pix_ce) begin
            rgb_s1 <= {bus.vga_r, bus.vga_g, bus.vga_b};
        end
    end

    assign hs_edge = bus.pix_ce & hs_fall;
    assign vs_edge = bus.pix_ce & vs_fall;

    // h_next/v_next are the coordinates of the sample currently held in rgb_s1.
    always_comb begin
        h_next = hs_edge ? '0 : sat_inc(h_cnt);
        v_next = v_cnt;
        if (vs_edge) begin
            v_next = '0;
        end else if (hs_edge) begin
            v_next = sat_inc(v_cnt);
        end
    end

    assign h_len     = {1'b0, h_cnt} + 11'd1;
    assign v_len     = {1'b0, v_cnt} + 11'd1;
    assign line_err  = hs_edge && (state != ST_UNLOCKED) && (h_len != H_TOTAL);
    assign frame_err = vs_edge && (state != ST_UNLOCKED) && (v_len != V_TOTAL);

    always_comb begin
        state_next   = state;
        win_err_next = win_err;
        err_inc      = 1'b0;
        case (state)
            ST_UNLOCKED: begin
                if (vs_edge) begin
                    state_next   = ST_CHECK;
                    win_err_next = 1'b0;
                end
            end
            ST_CHECK: begin
                if (vs_edge) begin
                    win_err_next = 1'b0;
                    if (!(win_err || line_err || frame_err)) begin
                        state_next = ST_LOCKED;
                    end
                end else if (line_err) begin
                    win_err_next = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (line_err || frame_err) begin
                    state_next = ST_UNLOCKED;
                    err_inc    = 1'b1;
                end
            end
            default: state_next = ST_UNLOCKED;
        endcase
    end

    assign active = (state == ST_LOCKED) &&
                    (h_next >= HA0) && (h_next < HA1) &&
                    (v_next >= VA0) && (v_next < VA1);

    assign bus.locked = (state == ST_LOCKED);

    always_ff @(posedge clk_50) begin
        if (rst) begin
            state           <= ST_UNLOCKED;
            win_err         <= 1'b0;
            h_cnt           <= '0;
            v_cnt           <= '0;
            bus.err_cnt     <= '0;
            bus.pix_x       <= '0;
            bus.pix_y       <= '0;
            bus.pix_rgb     <= '0;
            bus.pix_valid   <= 1'b0;
            bus.line_start  <= 1'b0;
            bus.frame_start <= 1'b0;
`ifdef VGA_SYNC_DECODER_STATS_EN
            bus.meas_h_total <= '0;
            bus.meas_v_total <= '0;
`endif
        end else begin
            bus.pix_valid   <= 1'b0;
            bus.line_start  <= 1'b0;
            bus.frame_start <= 1'b0;
            if (bus.pix_ce) begin
                h_cnt   <= h_next;
                v_cnt   <= v_next;
                state   <= state_next;
                win_err <= win_err_next;
                if (err_inc && (bus.err_cnt != 8'hFF)) begin
                    bus.err_cnt <= bus.err_cnt + 8'd1;
                end
                if (active) begin
                    bus.pix_valid   <= 1'b1;
                    bus.pix_x       <= h_next - HA0;
                    bus.pix_y       <= v_next - VA0;
                    bus.pix_rgb     <= rgb_s1;
                    bus.line_start  <= (h_next == HA0);
                    bus.frame_start <= (h_next == HA0) && (v_next == VA0);
                end
`ifdef VGA_SYNC_DECODER_STATS_EN
                if (hs_edge) begin
                    bus.meas_h_total <= h_cnt + 10'd1;
                end
                if (vs_edge) begin
                    bus.meas_v_total <= v_cnt + 10'd1;
                end
`endif
            end
        end
    end

endmodule
